// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   state_e    : access FSM states
//   mem_req_t  : access context latched when a memory op is accepted
//   BYTE_SIZE / DWORD_SIZE : values of the byte-op flag
//   BE_ALL     : byte enables for a full 64-bit access
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic       BYTE_SIZE  = 1'b1;
    localparam logic       DWORD_SIZE = 1'b0;
    localparam logic [7:0] BE_ALL     = 8'hFF;

    typedef struct packed {
        logic [63:0] addr;        // effective address, doubles as the ALU result
        logic [63:0] data;        // store data (Rt)
        logic        byte_op;
        logic        we;
        logic        mem_to_reg;
        logic        reg_we;
        logic [4:0]  rd;
    } mem_req_t;

    // A 64-bit access must be 8-byte aligned; byte accesses never fault.
    function automatic logic misaligned(input logic byte_op, input logic [2:0] addr_lo);
        return (byte_op == DWORD_SIZE) && (addr_lo != 3'd0);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port.
//   master : the MEM stage (drives req/we/addr/wdata/be, receives rdata/ack)
//   slave  : the data memory
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Combinational data steering for the MEM stage.
//   byte_op    in  : 1 = byte access
//   addr_lo    in  : address bits [2:0]
//   rdata      in  : raw 64-bit read data
//   store_data in  : store operand
//   load_data  out : byte-selected, zero-extended (or full) load result
//   wdata      out : store data, byte replicated to all lanes for byte stores
//   be         out : byte enables
module load_align
    import mem_stage_pkg::*;
(
    input  logic        byte_op,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] rdata,
    input  logic [63:0] store_data,
    output logic [63:0] load_data,
    output logic [63:0] wdata,
    output logic [7:0]  be
);
    always_comb begin
        load_data = rdata;
        wdata     = store_data;
        be        = BE_ALL;
        if (byte_op == BYTE_SIZE) begin
            load_data = {56'd0, rdata[{addr_lo, 3'b000} +: 8]};
            wdata     = {8{store_data[7:0]}};
            be        = 8'd1 << addr_lo;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/ack data-memory port, stalls the
// upstream pipeline while an access is outstanding, and forms the
// write-back triple for MEM/WB.
//   clk, reset           : clock, synchronous active-high reset
//   *_MEM inputs         : EX/MEM register contents
//   dmem                 : data-memory port (master side)
//   stall_MEM            : hold PC, IF/ID, ID/EX, EX/MEM
//   mem_err              : one-cycle pulse on misalignment or timeout
//   *_toWB outputs       : write-back enable, data, destination
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_MEM,
    input  logic                memRead_MEM,
    input  logic                memWrite_MEM,
    input  logic                memToReg_MEM,
    input  logic                byteOp_MEM,
    input  logic [63:0]         ALUResult_MEM,
    input  logic [63:0]         storeData_MEM,
    input  logic                regWrite_E_MEM,
    input  logic [4:0]          regWrite_MEM,
    mem_access_stage_if.master  dmem,
    output logic                stall_MEM,
    output logic                mem_err,
    output logic                regWrite_E_toWB,
    output logic [63:0]         WriteData_toWB,
    output logic [4:0]          regWrite_toWB
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              mem_err_q, mem_err_d;
    mem_req_t          info_q, info_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [63:0]       load_data;

    wire memop = valid_MEM & (memRead_MEM | memWrite_MEM);

    load_align u_align (
        .byte_op    (info_q.byte_op),
        .addr_lo    (info_q.addr[2:0]),
        .rdata      (rdata_q),
        .store_data (info_q.data),
        .load_data  (load_data),
        .wdata      (dmem.dmem_wdata),
        .be         (dmem.dmem_be)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_d     = req_q;
        mem_err_d = 1'b0;
        info_d    = info_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (memop) begin
                info_d = '{addr: ALUResult_MEM, data: storeData_MEM, byte_op: byteOp_MEM,
                           we: memWrite_MEM, mem_to_reg: memToReg_MEM,
                           reg_we: regWrite_E_MEM, rd: regWrite_MEM};
                cnt_d   = '0;
                rdata_d = '0;
                if (misaligned(byteOp_MEM, ALUResult_MEM[2:0])) begin
                    // Fault immediately without touching the bus.
                    err_d     = 1'b1;
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Ack wins over a timeout landing in the same cycle.
                if (dmem.dmem_ack) begin
                    rdata_d = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            mem_err_q <= 1'b0;
            info_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            req_q     <= req_d;
            mem_err_q <= mem_err_d;
            info_q    <= info_d;
            rdata_q   <= rdata_d;
        end
    end

    assign dmem.dmem_req  = req_q;
    assign dmem.dmem_we   = info_q.we;
    assign dmem.dmem_addr = {info_q.addr[63:3], 3'b000};
    assign mem_err        = mem_err_q;

    // Write-back: pass-through when idle, bubble while an access is in
    // flight, latched result in DONE (the cycle MEM/WB captures it).
    always_comb begin
        stall_MEM       = 1'b0;
        WriteData_toWB  = ALUResult_MEM;
        regWrite_E_toWB = valid_MEM & regWrite_E_MEM;
        regWrite_toWB   = regWrite_MEM;
        case (state_q)
            IDLE: if (memop) begin
                stall_MEM       = 1'b1;
                regWrite_E_toWB = 1'b0;
            end
            BUSY: begin
                stall_MEM       = 1'b1;
                regWrite_E_toWB = 1'b0;
            end
            DONE: begin
                WriteData_toWB  = info_q.mem_to_reg ? load_data : info_q.addr;
                regWrite_E_toWB = info_q.reg_we & ~err_q;
                regWrite_toWB   = info_q.rd;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipelined CPU; sits between the EX/MEM pipeline register and the MEM/WB register (MEM_WB_reg).
- Drives a request/acknowledge data-memory port for LDUR/LDURB/STUR/STURB and stalls upstream until the access completes.
- Produces the write-back triple (enable, data, destination) consumed by MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without dmem_ack before the access is aborted.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- valid_MEM  in  1  EX/MEM holds a real instruction
- memRead_MEM  in  1  load
- memWrite_MEM  in  1  store
- memToReg_MEM  in  1  write-back selects load data
- byteOp_MEM  in  1  1 = byte access (LDURB/STURB), 0 = 64-bit
- ALUResult_MEM  in  64  effective address / ALU result
- storeData_MEM  in  64  store data (Rt)
- regWrite_E_MEM  in  1  register write enable
- regWrite_MEM  in  5  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  write
- dmem_addr  out  64  aligned address {addr[63:3],3'b0}
- dmem_wdata  out  64  write data
- dmem_be  out  8  byte enables
- dmem_rdata  in  64  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- stall_MEM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- mem_err  out  1  one-cycle pulse: misaligned access or timeout
- regWrite_E_toWB  out  1  to MEM/WB
- WriteData_toWB  out  64  to MEM/WB
- regWrite_toWB  out  5  to MEM/WB

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- memop = valid_MEM & (memRead_MEM | memWrite_MEM).
- FSM states: IDLE, BUSY, DONE. Reset: IDLE, dmem_req=0, counter=0, mem_err=0, latched result/flags cleared.
- IDLE, no memop:
  - Pure pass-through, combinational.
  - WriteData_toWB=ALUResult_MEM; regWrite_E_toWB=valid_MEM&regWrite_E_MEM; stall_MEM=0.
- IDLE, memop, aligned (byteOp=1 or addr[2:0]=0):
  - stall_MEM=1 combinationally.
  - Latch addr, data, size, memToReg, regWrite_E, regWrite.
  - Next state BUSY; dmem_req=1 from the next cycle.
- IDLE, memop, 64-bit access with addr[2:0]!=0:
  - No request issued; stall_MEM=1.
  - Next state DONE with err flag set.
- BUSY:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held stable; stall_MEM=1; counter increments.
  - On dmem_ack: capture dmem_rdata, dmem_req=0 next cycle, go to DONE.
  - If counter reaches TIMEOUT_CYCLES with no ack: drop request, go to DONE with err flag set.
  - Ack takes priority over timeout in the same cycle.
- DONE:
  - stall_MEM=0, so upstream advances and MEM/WB captures on this edge.
  - mem_err=err flag.
  - Next state IDLE; memop is not re-launched in DONE.
- Write-back outputs:
  - IDLE-with-memop and BUSY: regWrite_E_toWB=0 (bubble).
  - DONE: WriteData_toWB = memToReg ? loadData : latched ALU result; regWrite_E_toWB = latched regWrite_E & !err; regWrite_toWB = latched regWrite.
- Byte ops:
  - Load: loadData = zero-extended rdata[8*addr[2:0] +: 8].
  - Store: wdata = storeData[7:0] replicated to 8 lanes; be = 1<<addr[2:0].
- 64-bit ops: be=8'hFF; loadData=rdata.
- dmem_ack outside BUSY: ignored.
- Reset mid-BUSY: dmem_req low after the reset edge; the pending result is discarded.
- Minimum memop latency: 3 cycles with ack on the first BUSY cycle.

Decomposition:
- Package mem_stage_pkg:
  - state enum {IDLE, BUSY, DONE}
  - BYTE_SIZE/DWORD_SIZE constants
  - BE_ALL=8'hFF
- Sub-module load_align (combinational): byte select and zero-extend for loads, lane replication and byte-enable generation for stores.

Test Plan:
- ALU op, valid=1, regWrite_E=1, ALUResult=64'h1234, rd=5 -> same cycle: WriteData_toWB=64'h1234, regWrite_toWB=5, regWrite_E_toWB=1, stall_MEM=0, no dmem_req.
- LDUR at addr 64'h40, ack on 2nd BUSY cycle with rdata=64'hDEADBEEF_CAFEF00D, rd=3 -> stall high for 3 cycles; DONE: WriteData_toWB=64'hDEADBEEFCAFEF00D, regWrite_E_toWB=1.
- LDURB at addr 64'h45, rdata=64'h1122334455667788 -> dmem_addr=64'h40, WriteData_toWB=64'h33.
- STURB at addr 64'h42, storeData=64'hAB -> dmem_we=1, be=8'h04, wdata=64'hABABABABABABABAB; DONE regWrite_E_toWB=0.
- LDUR at addr 64'h43 -> no dmem_req; mem_err pulses 1 cycle; regWrite_E_toWB=0; stall is 1 cycle.
- LDUR with ack never arriving, TIMEOUT_CYCLES=16 -> dmem_req drops after 16 BUSY cycles; mem_err pulse; regWrite_E_toWB=0. Repeat with reset asserted in BUSY cycle 2 -> next cycle IDLE, dmem_req=0, stall_MEM driven by current inputs only.
